// File: rtl/i2c_seq_pkg.sv
// ---------------------------------------------------------------------------
// i2c_seq_pkg
// Shared definitions for the I2C command sequencer:
//   - seq_state_e : one-hot sequencer states (S_IDLE/S_LAUNCH/S_BUSY/S_CAPT)
//   - CMD_W       : command width, {addr[6:0], rw}
//   - RW_READ     : value of the rw bit that marks a read
//   - cmd_is_read : helper that decodes the rw bit of a command byte
// ---------------------------------------------------------------------------
package i2c_seq_pkg;

    localparam int   CMD_W   = 8;
    localparam logic RW_READ = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_LAUNCH = 4'b0010,
        S_BUSY   = 4'b0100,
        S_CAPT   = 4'b1000
    } seq_state_e;

    // The rw flag lives in the LSB of the command byte
    function automatic logic cmd_is_read(input logic [CMD_W-1:0] cmd);
        return (cmd[0] == RW_READ);
    endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// ---------------------------------------------------------------------------
// i2c_cmd_fifo
// Small synchronous FIFO holding host commands until the sequencer launches
// them. Storage is a register array; the head entry is presented straight
// from those registers so the sequencer can load it on the pop edge.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write request / data (ignored when full)
//   pop             : read request (ignored when empty)
//   head            : entry at the read pointer
//   full, empty     : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module i2c_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign empty_s   = (count_r == CNT_W'(0));
    assign push_ok_s = push & ~full_s;
    assign pop_ok_s  = pop & ~empty_s;

    assign full  = full_s;
    assign empty = empty_s;
    assign head  = mem_r[rd_ptr_r];

    // Storage array and write pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Read pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= '0;
        end else if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_r <= rd_ptr_r;
        end
    end

    // Occupancy counter; simultaneous push and pop leave it unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_cmd_sequencer
// Command stage in front of the I2C master controller. Host commands
// ({addr[6:0], rw}) are queued in a FIFO and launched one at a time: the
// command byte is placed on i2c_data and i2c_init is held high until the
// controller's bussy flag rises. The end of the transaction is the falling
// edge of bussy; for reads the controller's data_out is captured and
// returned with a one-cycle rd_valid strobe.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   cmd_data/valid/ready  : host command handshake (ready = FIFO not full)
//   i2c_init, i2c_data    : launch request and command byte to controller
//   i2c_bussy             : controller busy flag
//   i2c_data_out          : controller read data
//   rd_data, rd_valid     : returned read byte and its strobe
//   idle                  : FIFO empty and sequencer in S_IDLE
//   err                   : sticky launch-timeout flag
// Build option:
//   I2C_SEQ_TIMEOUT_EN    : when defined, a launch that sees no bussy rise
//                           within START_WAIT cycles is dropped and err is
//                           set; otherwise S_LAUNCH waits forever, err = 0.
// ---------------------------------------------------------------------------
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int START_WAIT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] cmd_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic             i2c_init,
    output logic [CMD_W-1:0] i2c_data,
    input  logic             i2c_bussy,
    input  logic [7:0]       i2c_data_out,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             idle,
    output logic             err
);

    seq_state_e       state_r;
    seq_state_e       state_nx_s;
    logic             bussy_q_r;
    logic             rise_s;
    logic             fall_s;
    logic             pop_s;
    logic             capt_entry_s;
    logic             timeout_s;
    logic             cur_rw_r;
    logic             init_r;
    logic [CMD_W-1:0] data_r;
    logic [7:0]       rd_data_r;
    logic             rd_valid_r;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CMD_W-1:0] fifo_head_s;

    assign cmd_ready = ~fifo_full_s;
    assign idle      = fifo_empty_s & (state_r == S_IDLE);
    assign i2c_init  = init_r;
    assign i2c_data  = data_r;
    assign rd_data   = rd_data_r;
    assign rd_valid  = rd_valid_r;

    // Edges are taken against the registered copy, so a bussy that is
    // already high when S_LAUNCH is entered must drop and rise again
    // before it counts as the controller accepting the launch.
    assign rise_s = i2c_bussy & ~bussy_q_r;
    assign fall_s = ~i2c_bussy & bussy_q_r;

    i2c_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid & ~fifo_full_s),
        .push_data (cmd_data),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Next-state decode and per-cycle control strobes
    always_comb begin
        state_nx_s   = state_r;
        pop_s        = 1'b0;
        capt_entry_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    state_nx_s = S_LAUNCH;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_LAUNCH: begin
                if (rise_s) begin
                    state_nx_s = S_BUSY;
                end else if (timeout_s) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_LAUNCH;
                end
            end
            S_BUSY: begin
                if (fall_s) begin
                    if (cur_rw_r == RW_READ) begin
                        state_nx_s   = S_CAPT;
                        capt_entry_s = 1'b1;
                    end else begin
                        state_nx_s = S_IDLE;
                    end
                end else begin
                    state_nx_s = S_BUSY;
                end
            end
            S_CAPT: begin
                state_nx_s = S_IDLE;
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State register and bussy history
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            bussy_q_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            bussy_q_r <= i2c_bussy;
        end
    end

    // Launch outputs: init is high exactly while the FSM sits in S_LAUNCH,
    // and the command byte is loaded from the FIFO head on the pop edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_r   <= 1'b0;
            data_r   <= '0;
            cur_rw_r <= 1'b0;
        end else begin
            init_r <= (state_nx_s == S_LAUNCH);
            if (pop_s) begin
                data_r   <= fifo_head_s;
                cur_rw_r <= cmd_is_read(fifo_head_s);
            end else begin
                data_r   <= data_r;
                cur_rw_r <= cur_rw_r;
            end
        end
    end

    // Read return: data_out is sampled on the bussy-fall cycle so that
    // rd_data is already valid during the single S_CAPT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r  <= 8'h00;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= capt_entry_s;
            if (capt_entry_s) begin
                rd_data_r <= i2c_data_out;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [15:0] wait_cnt_r;
    logic        err_r;

    // Fires on the START_WAIT-th launch cycle without a bussy rise
    assign timeout_s = (state_r == S_LAUNCH) && !rise_s &&
                       (wait_cnt_r == 16'(START_WAIT - 1));
    assign err       = err_r;

    // Launch wait counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 16'd0;
            err_r      <= 1'b0;
        end else begin
            if ((state_r == S_LAUNCH) && !timeout_s) begin
                wait_cnt_r <= wait_cnt_r + 16'd1;
            end else begin
                wait_cnt_r <= 16'd0;
            end
            if (timeout_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end
`else
    logic [15:0] unused_start_wait_s;

    assign unused_start_wait_s = 16'(START_WAIT);
    assign timeout_s           = 1'b0;
    assign err                 = 1'b0;
`endif

endmodule
